// File: rtl/uart_receiver.sv
// 8N1 UART receiver that collects eight consecutive good frames into a 64-bit word.
// Start bit is re-checked at mid-bit; data and stop bits are sampled one bit period after that.

module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_i,
  output logic rx_s_o
);
  logic meta_q, sync_q;

  // Both flops reset high so a reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= rx_i;
      sync_q <= meta_q;
    end
  end

  assign rx_s_o = sync_q;
endmodule

module uart_receiver #(
  parameter int clks_per_bit = 868
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx,
  output logic [63:0] received_array,
  output logic        bytes_are_received,
  output logic        framing_error,
  output logic        receive_active
);
  localparam int CNT_W = (clks_per_bit > 2) ? $clog2(clks_per_bit) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(clks_per_bit - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'((clks_per_bit - 1) / 2);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [2:0]       byte_q, byte_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0][7:0]  buf_q, buf_d;
  logic [63:0]      arr_q, arr_d;
  logic             done_q, done_d;
  logic             ferr_q, ferr_d;
  logic             rx_s;

  uart_rx_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx_i   (uart_rx),
    .rx_s_o (rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      shift_q <= '0;
      buf_q   <= '0;
      arr_q   <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shift_q <= shift_d;
      buf_q   <= buf_d;
      arr_q   <= arr_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    buf_d   = buf_q;
    arr_d   = arr_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == LAST) begin
          cnt_d          = '0;
          shift_d[bit_q] = rx_s;
          bit_d          = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s) begin
            buf_d[byte_q] = shift_q;
            if (byte_q == 3'd7) begin
              arr_d  = buf_d;
              done_d = 1'b1;
              byte_d = '0;
            end else begin
              byte_d = byte_q + 3'd1;
            end
          end else begin
            // Bad stop bit drops the whole partial set, not just this byte.
            ferr_d = 1'b1;
            byte_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign received_array     = arr_q;
  assign bytes_are_received = done_q;
  assign framing_error      = ferr_q;
  assign receive_active     = (state_q != IDLE) || (byte_q != 3'd0);
endmodule
